// File: rtl/adc_level_indicator.sv
// adc_level_indicator: turns a 12-bit ADC sample stream into blue/green level LEDs.
// The level only changes after a hysteresis band check and a persistence filter.
// "No data yet" is shown with both LEDs off. A one-cycle level_chg strobe marks each change.
// Optional feature: define LEVEL_STALE_EN to drop back to the unknown state after
// STALE_CYCLES cycles without a valid sample. In that state both LEDs are off and stale=1.
module adc_level_indicator #(
   parameter int DATA_W       = 12,
   parameter int THRESH       = 2048,
   parameter int HYST         = 64,
   parameter int PERSIST      = 4,
   parameter int STALE_CYCLES = 1000000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              DATA_VALID,
   input  logic [DATA_W-1:0] DATA,
   output logic              led_b,
   output logic              led_g,
   output logic              level_chg,
   output logic              stale
);

   localparam int CW      = $clog2(PERSIST + 1);
   localparam int MAXV    = (1 << DATA_W) - 1;
   // Band limits saturate to the sample range.
   localparam int UPPER_I = (THRESH + HYST > MAXV) ? MAXV : THRESH + HYST;
   localparam int LOWER_I = (THRESH - HYST < 0) ? 0 : THRESH - HYST;
   localparam logic [DATA_W:0] UPPER    = (DATA_W+1)'(UPPER_I);
   localparam logic [DATA_W:0] LOWER    = (DATA_W+1)'(LOWER_I);
   localparam logic [DATA_W:0] THRESH_X = (DATA_W+1)'(THRESH);
   localparam logic [CW-1:0]   LAST     = CW'(PERSIST - 1);

   typedef enum logic [1:0] {S_UNK, S_LOW, S_HIGH} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     cnt_q, cnt_d;
   logic              chg_d, led_b_d, led_g_d;
   logic [DATA_W:0]   sample;

   assign sample = {1'b0, DATA};

`ifdef LEVEL_STALE_EN
   localparam int SW = $clog2(STALE_CYCLES + 1);
   localparam logic [SW-1:0] STALE_MAX = SW'(STALE_CYCLES);
   logic [SW-1:0] scnt_q, scnt_d;
   logic          stale_d;
`endif

   // State, persistence counter and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_UNK;
         cnt_q     <= '0;
         led_b     <= 1'b0;
         led_g     <= 1'b0;
         level_chg <= 1'b0;
`ifdef LEVEL_STALE_EN
         scnt_q    <= '0;
         stale     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         led_b     <= led_b_d;
         led_g     <= led_g_d;
         level_chg <= chg_d;
`ifdef LEVEL_STALE_EN
         scnt_q    <= scnt_d;
         stale     <= stale_d;
`endif
      end
   end

   // Next state: UNK resolves on the first sample. LOW/HIGH flip only after PERSIST qualifying samples in a row.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      chg_d   = 1'b0;
`ifdef LEVEL_STALE_EN
      scnt_d  = scnt_q;
      stale_d = stale;
`endif
      if (DATA_VALID) begin
`ifdef LEVEL_STALE_EN
         scnt_d  = '0;
         stale_d = 1'b0;
`endif
         case (state_q)
            S_UNK: begin
               state_d = (sample <= THRESH_X) ? S_LOW : S_HIGH;
               cnt_d   = '0;
               chg_d   = 1'b1;
            end
            S_LOW: begin
               if (sample > UPPER) begin
                  if (cnt_q == LAST) begin
                     state_d = S_HIGH;
                     cnt_d   = '0;
                     chg_d   = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            S_HIGH: begin
               if (sample <= LOWER) begin
                  if (cnt_q == LAST) begin
                     state_d = S_LOW;
                     cnt_d   = '0;
                     chg_d   = 1'b1;
                  end else begin
                     cnt_d = cnt_q + CW'(1);
                  end
               end else begin
                  cnt_d = '0;
               end
            end
            default: begin
               state_d = S_UNK;
               cnt_d   = '0;
            end
         endcase
      end
`ifdef LEVEL_STALE_EN
      // Idle cycles advance the stale timer. Going stale forgets the level without a change strobe.
      else if (scnt_q != STALE_MAX) begin
         scnt_d = scnt_q + SW'(1);
         if (scnt_d == STALE_MAX) begin
            state_d = S_UNK;
            cnt_d   = '0;
            stale_d = 1'b1;
         end
      end
`endif
   end

   // LED decode of the next state, so the LED flops track the state flop exactly.
   always_comb begin
      led_b_d = (state_d == S_LOW);
      led_g_d = (state_d == S_HIGH);
   end

`ifndef LEVEL_STALE_EN
   assign stale = 1'b0;
`endif

endmodule

// File: tb/tb_adc_level_indicator.sv
// Directed bench for adc_level_indicator (THRESH=2048, HYST=64, PERSIST=4 -> band 1984..2112).
module tb_adc_level_indicator;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        DATA_VALID = 1'b0;
   logic [11:0] DATA = '0;
   logic        led_b, led_g, level_chg, stale;
   int          checks = 0;
   int          failures = 0;

   adc_level_indicator #(
      .DATA_W(12), .THRESH(2048), .HYST(64), .PERSIST(4), .STALE_CYCLES(10)
   ) dut (
      .clk(clk), .rst_n(rst_n), .DATA_VALID(DATA_VALID), .DATA(DATA),
      .led_b(led_b), .led_g(led_g), .level_chg(level_chg), .stale(stale)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One valid sample. Returns 1 ns after the edge that consumed it, with valid dropped.
   // The data bus then carries junk, which the DUT must ignore.
   task automatic sample(input logic [11:0] d);
      @(negedge clk);
      DATA_VALID = 1'b1;
      DATA = d;
      @(posedge clk);
      #1;
      DATA_VALID = 1'b0;
      DATA = ~d;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic leds(input string tag, input logic b, input logic g, input logic c);
      chk({tag, "_b"}, led_b, b);
      chk({tag, "_g"}, led_g, g);
      chk({tag, "_chg"}, level_chg, c);
   endtask

   initial begin
      // Reset state
      #3;
      leds("rst", 0, 0, 0);
      chk("rst_stale", stale, 0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(3);
      leds("unk_idle", 0, 0, 0);

      // First sample goes straight to LOW
      sample(12'd1000);
      leds("first_low", 1, 0, 1);
      idle(1);
      leds("first_low_hold", 1, 0, 0);

      // Four 2113 samples with gaps flip the level to HIGH
      for (int i = 0; i < 3; i++) begin
         sample(12'd2113);
         leds("up_pend", 1, 0, 0);
         idle(1);
      end
      sample(12'd2113);
      leds("up_flip", 0, 1, 1);
      idle(1);
      leds("up_flip_hold", 0, 1, 0);

      // 1985 never qualifies from HIGH
      for (int i = 0; i < 4; i++) sample(12'd1985);
      leds("hi_1985", 0, 1, 0);

      // Four 1984 samples give LOW with exactly one pulse
      for (int i = 0; i < 3; i++) sample(12'd1984);
      leds("dn_pend", 0, 1, 0);
      sample(12'd1984);
      leds("dn_flip", 1, 0, 1);
      sample(12'd1984);
      leds("dn_single", 1, 0, 0);

      // 2112 is the band edge and does not qualify
      for (int i = 0; i < 4; i++) sample(12'd2112);
      leds("lo_2112", 1, 0, 0);

      // An in-band sample clears the count
      for (int i = 0; i < 3; i++) sample(12'd3000);
      sample(12'd2050);
      for (int i = 0; i < 3; i++) sample(12'd3000);
      leds("inband_clr", 1, 0, 0);
      sample(12'd3000);
      leds("inband_flip", 0, 1, 1);

      // Reset mid-count forces the reset values at once
      sample(12'd100);
      sample(12'd100);
      rst_n = 1'b0;
      #1;
      leds("async_rst", 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      sample(12'd4000);
      leds("rst_resume", 0, 1, 1);
      // The count from before reset must be gone
      for (int i = 0; i < 3; i++) sample(12'd100);
      leds("rst_cnt_clr", 0, 1, 0);
      sample(12'd100);
      leds("rst_cnt_flip", 1, 0, 1);

      // Back to HIGH for the idle/stale test
      for (int i = 0; i < 4; i++) sample(12'd4000);
      leds("hi_again", 0, 1, 1);
`ifdef LEVEL_STALE_EN
      idle(9);
      leds("stale_pre", 0, 1, 0);
      chk("stale_pre_flag", stale, 0);
      idle(1);
      leds("stale_hit", 0, 0, 0);
      chk("stale_hit_flag", stale, 1);
      idle(5);
      chk("stale_sat_flag", stale, 1);
      sample(12'd100);
      leds("stale_exit", 1, 0, 1);
      chk("stale_exit_flag", stale, 0);
`else
      idle(50);
      leds("hold_idle", 0, 1, 0);
      chk("hold_stale", stale, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end
endmodule

// File: doc/adc_level_indicator.md
# adc_level_indicator

Parametrised ADC level indicator that turns the 12-bit sample stream from the ADC front end into blue/green status LEDs. It replaces the single-compare LED stage with a hysteresis band, a persistence filter against noisy samples, a defined "no data yet" state, and a one-cycle change strobe. It sits between the ADC sample interface and the board LED pins.

## Interface
- `DATA_W`, 12: sample width in bits.
- `THRESH`, 2048: nominal switching level, 1.65 V at 12 bits.
- `HYST`, 64: half-width of the hysteresis band, in LSBs.
- `PERSIST`, 4: consecutive qualifying valid samples needed to change level. Must be ≥1.
- `STALE_CYCLES`, 1000000: clock cycles without `DATA_VALID` before the data is declared stale. Only used with `LEVEL_STALE_EN`.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst_n`, in, 1: reset, asynchronous and active-low.
- `DATA_VALID`, in, 1: `DATA` is a valid sample this cycle.
- `DATA`, in, DATA_W: unsigned ADC sample.
- `led_b`, out, 1: level LOW (sample at or below the band).
- `led_g`, out, 1: level HIGH (sample above the band).
- `level_chg`, out, 1: one-cycle pulse on every change of level.
- `stale`, out, 1: stale-data flag. Tied to 0 without `LEVEL_STALE_EN`.

## Operation
- Band limits are computed in DATA_W+1 bits and saturate.
  - UPPER = min(THRESH+HYST, 2^DATA_W−1).
  - LOWER = max(THRESH−HYST, 0).
- State machine has three states: UNK, LOW, HIGH.
  - Reset enters UNK.
  - UNK: both LEDs off. The first valid sample goes directly to LOW if `DATA` ≤ THRESH, else to HIGH. No persistence applies. `level_chg` pulses.
  - LOW: a valid sample with `DATA` > UPPER is qualifying.
  - HIGH: a valid sample with `DATA` ≤ LOWER is qualifying.
  - Samples inside the band, or on the current side, are non-qualifying.
- Persistence counter `cnt`, width clog2(PERSIST+1):
  - A qualifying valid sample increments it.
  - A non-qualifying valid sample clears it.
  - Cycles with `DATA_VALID`=0 leave it unchanged.
  - When a qualifying sample would bring `cnt` to PERSIST, the level flips, `cnt` clears and `level_chg` pulses.
- LED outputs:
  - `led_b`=1 exactly in LOW, `led_g`=1 exactly in HIGH.
  - Both LEDs are never 1 together.
- With HYST=0 and PERSIST=1, post-UNK behaviour is a plain `DATA` ≤ THRESH compare.

## Timing
- All outputs are registered.
- Reset values:
  - `led_b`=0, `led_g`=0, `level_chg`=0, `stale`=0.
  - state UNK, `cnt`=0, stale counter 0.
- Latency: a sample presented with `DATA_VALID` at rising edge k that causes a transition is visible on the LEDs and on `level_chg` after edge k. This is a one-cycle latency.
- `level_chg` is high for exactly one cycle per transition. Back-to-back transitions give back-to-back pulses.
- Reset assertion mid-count or mid-pulse immediately forces the reset values. Operation resumes from UNK on the first valid sample after `rst_n` deasserts.
- `DATA` is ignored whenever `DATA_VALID`=0.

## Configuration
- `LEVEL_STALE_EN` defined:
  - A stale counter counts cycles with `DATA_VALID`=0, saturating at STALE_CYCLES, and clears on any valid sample.
  - On reaching STALE_CYCLES: state goes to UNK, `cnt` clears, LEDs turn off and `stale`=1. No `level_chg` pulse is issued.
  - The next valid sample clears `stale` in the same edge and performs the UNK rule.
- `LEVEL_STALE_EN` undefined:
  - No stale counter is built and `stale` is constant 0.
  - The level holds indefinitely without data.

## Test plan
Defaults for all scenarios: THRESH=2048, HYST=64, PERSIST=4, giving UPPER=2112 and LOWER=1984.
1. Reset, then one valid 1000 → `led_b`=1 and `level_chg` pulse one cycle later. Before that sample both LEDs are 0.
2. From LOW, four valid 2113 samples separated by `DATA_VALID`=0 gaps → `led_g`=1 after the 4th. Sending 2112 four times instead → stays LOW.
3. From LOW, three 3000, then one 2050, then three 3000 → stays LOW, because the in-band sample clears `cnt`. A 4th 3000 → HIGH.
4. From HIGH, four 1984 → LOW with a single `level_chg` pulse. Four 1985 → stays HIGH.
5. Assert `rst_n`=0 after two qualifying samples → LEDs 0 immediately. After release, a valid 4000 → HIGH directly.
6. With `LEVEL_STALE_EN` and STALE_CYCLES=10, from HIGH hold `DATA_VALID`=0 for 10 cycles → LEDs 0 and `stale`=1. A valid 100 → `stale`=0 and `led_b`=1.
